puf_challenge_sequencer: RTL

Sequences challenge application to the XOR-PUF input network and its two downstream arbiter chains. Accepts a challenge over a valid/ready handshake and drives the input-network challenge bus. It then launches NUM_EVAL arbiter races, samples the y/z arbiter response bits after a settle window, and majority-votes the XORed bits into one response bit with a stability flag. Sits between the host/UART challenge source and the inputNetwork + arbiter datapath.

---
 rtl/puf_challenge_sequencer.sv | 107 ++++++++++
 1 files changed

// File: rtl/puf_challenge_sequencer.sv
// Challenge sequencer for the XOR-PUF: launches repeated arbiter races per
// challenge and majority-votes the XORed y/z responses into one bit.
module puf_challenge_sequencer #(
  parameter int CW            = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_EVAL      = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] chal_in,
  input  logic          chal_valid,
  output logic          chal_ready,
  output logic [CW-1:0] net_x,
  output logic          arb_launch,
  input  logic          arb_y_resp,
  input  logic          arb_z_resp,
  output logic          resp_out,
  output logic          resp_stable,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          busy
);

  localparam int EW = $clog2(NUM_EVAL + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  if (NUM_EVAL < 1 || (NUM_EVAL % 2) == 0 || SETTLE_CYCLES < 1) begin : g_bad_params
    $error("puf_challenge_sequencer: NUM_EVAL must be odd >=1, SETTLE_CYCLES >=1");
  end

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  state_t        state;
  logic [EW-1:0] eval_cnt;
  logic [EW-1:0] ones_cnt;
  logic [EW-1:0] ones_nxt;
  logic [SW-1:0] settle_cnt;

  // Vote count including the sample taken in the current SAMPLE cycle
  assign ones_nxt   = ones_cnt + EW'(arb_y_resp ^ arb_z_resp);
  assign chal_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      net_x       <= '0;
      arb_launch  <= 1'b0;
      resp_out    <= 1'b0;
      resp_stable <= 1'b0;
      resp_valid  <= 1'b0;
      eval_cnt    <= '0;
      ones_cnt    <= '0;
      settle_cnt  <= '0;
    end else begin
      arb_launch <= 1'b0;
      unique case (state)
        IDLE: begin
          if (chal_valid) begin
            net_x      <= chal_in;
            eval_cnt   <= '0;
            ones_cnt   <= '0;
            arb_launch <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + SW'(1);
          if (settle_cnt == SW'(SETTLE_CYCLES - 1))
            state <= SAMPLE;
        end
        SAMPLE: begin
          ones_cnt <= ones_nxt;
          eval_cnt <= eval_cnt + EW'(1);
          if (eval_cnt == EW'(NUM_EVAL - 1)) begin
            resp_out    <= (int'(ones_nxt) > NUM_EVAL / 2);
            resp_stable <= (ones_nxt == '0) ||
                           (ones_nxt == EW'(NUM_EVAL));
            resp_valid  <= 1'b1;
            state       <= DONE;
          end else begin
            arb_launch <= 1'b1;
            state      <= LAUNCH;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
